// File: rtl/run_ctrl_if.sv
// run_ctrl_if: control/observation bundle between the run controller and its environment.
interface run_ctrl_if #(parameter int ROM_AW = 10);
  logic              go;
  logic              step;
  logic [31:0]       pc;
  logic              ecall;
  logic [31:0]       a7;
  logic [31:0]       a0;
  logic [ROM_AW-1:0] dbg_addr;
  logic [ROM_AW-1:0] rom_addr;
  logic              pc_en;
  logic              paused;
  logic              halted;
  logic              fault;
  logic [31:0]       disp;
  logic              disp_vld;
  logic [31:0]       icount;
  modport master (
    output go, step, pc, ecall, a7, a0, dbg_addr,
    input  rom_addr, pc_en, paused, halted, fault, disp, disp_vld, icount
  );
  modport slave (
    input  go, step, pc, ecall, a7, a0, dbg_addr,
    output rom_addr, pc_en, paused, halted, fault, disp, disp_vld, icount
  );
endinterface

// File: rtl/run_ctrl.sv
// run_ctrl: run/step/pause/halt sequencer for a single-cycle core with ECALL services.
module run_ctrl #(parameter int ROM_AW = 10) (
  input logic clk,
  input logic rst,
  run_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RUN, STEP, PAUSE, HALT, FAULT} state_t;
  state_t state, nxt;
  logic [31:0] icount_q, disp_q;
  logic disp_vld_q, active, bad, halt_ec, pause_ec, disp_ec, commit;
  always_comb begin
    active   = (state == RUN || state == STEP) && !rst;
    bad      = bus.pc[1:0] != 2'b00 || bus.pc[31:ROM_AW+2] != '0;
    halt_ec  = bus.ecall && bus.a7 == 32'd10;
    pause_ec = bus.ecall && bus.a7 == 32'd50;
    disp_ec  = bus.ecall && bus.a7 == 32'd34;
    commit   = active && !bad && !halt_ec;
    nxt      = state;
    case (state)
      IDLE, PAUSE: nxt = bus.go ? RUN : bus.step ? STEP : state;
      RUN:         nxt = bad ? FAULT : halt_ec ? HALT : pause_ec ? PAUSE : RUN;
      STEP:        nxt = bad ? FAULT : halt_ec ? HALT : PAUSE;
      default:     nxt = state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      icount_q   <= '0;
      disp_q     <= '0;
      disp_vld_q <= 1'b0;
    end else begin
      state      <= nxt;
      disp_vld_q <= commit && disp_ec;
      if (commit && disp_ec) disp_q <= bus.a0;
      if (commit && icount_q != 32'hFFFF_FFFF) icount_q <= icount_q + 32'd1;
    end
  end
  assign bus.rom_addr = active ? bus.pc[ROM_AW+1:2] : bus.dbg_addr;
  assign bus.pc_en    = commit;
  assign bus.paused   = state == PAUSE;
  assign bus.halted   = state == HALT;
  assign bus.fault    = state == FAULT;
  assign bus.disp     = disp_q;
  assign bus.disp_vld = disp_vld_q;
  assign bus.icount   = icount_q;
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed self-checking bench for run_ctrl with hand-computed expectations.
module tb_run_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int fails = 0;
  run_ctrl_if #(.ROM_AW(10)) bus();
  run_ctrl #(.ROM_AW(10)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    bus.go = 1'b1; bus.step = 1'b0; bus.pc = '0; bus.ecall = 1'b0;
    bus.a7 = '0; bus.a0 = '0; bus.dbg_addr = 10'h055;
    tick();
    #1;
    chk("rst_pc_en", {31'b0, bus.pc_en}, 32'd0);
    chk("rst_rom_addr", {22'b0, bus.rom_addr}, 32'h055);
    tick();
    rst = 1'b0; bus.go = 1'b0; bus.dbg_addr = 10'h123;
    #1;
    chk("rst_icount", bus.icount, 32'd0);
    chk("rst_flags", {28'b0, bus.paused, bus.halted, bus.fault, bus.disp_vld}, 32'd0);
    chk("rst_disp", bus.disp, 32'd0);
    chk("idle_rom_addr", {22'b0, bus.rom_addr}, 32'h123);
    chk("idle_pc_en", {31'b0, bus.pc_en}, 32'd0);
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.pc = 32'(4 * i);
      #1;
      chk($sformatf("run_pc_en_%0d", i), {31'b0, bus.pc_en}, 32'd1);
      chk($sformatf("run_rom_addr_%0d", i), {22'b0, bus.rom_addr}, 32'(i));
      tick();
    end
    chk("run_icount5", bus.icount, 32'd5);
    bus.pc = 32'd20; bus.ecall = 1'b1; bus.a7 = 32'd34; bus.a0 = 32'h8000_0000;
    #1;
    chk("disp_pc_en", {31'b0, bus.pc_en}, 32'd1);
    tick();
    bus.ecall = 1'b0; bus.pc = 32'd24;
    #1;
    chk("disp_val", bus.disp, 32'h8000_0000);
    chk("disp_vld_hi", {31'b0, bus.disp_vld}, 32'd1);
    chk("disp_icount", bus.icount, 32'd6);
    chk("disp_still_run", {31'b0, bus.pc_en}, 32'd1);
    tick();
    chk("disp_vld_lo", {31'b0, bus.disp_vld}, 32'd0);
    chk("disp_hold", bus.disp, 32'h8000_0000);
    bus.pc = 32'd28; bus.ecall = 1'b1; bus.a7 = 32'd50;
    #1;
    chk("pause_ec_pc_en", {31'b0, bus.pc_en}, 32'd1);
    tick();
    bus.ecall = 1'b0; bus.pc = 32'd32;
    #1;
    chk("paused_set", {31'b0, bus.paused}, 32'd1);
    chk("pause_icount", bus.icount, 32'd8);
    chk("pause_pc_en", {31'b0, bus.pc_en}, 32'd0);
    chk("pause_rom_addr", {22'b0, bus.rom_addr}, 32'h123);
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    #1;
    chk("step_paused_lo", {31'b0, bus.paused}, 32'd0);
    chk("step_pc_en", {31'b0, bus.pc_en}, 32'd1);
    chk("step_rom_addr", {22'b0, bus.rom_addr}, 32'd8);
    tick();
    bus.pc = 32'd36;
    #1;
    chk("step_back_paused", {31'b0, bus.paused}, 32'd1);
    chk("step_icount", bus.icount, 32'd9);
    chk("step_done_pc_en", {31'b0, bus.pc_en}, 32'd0);
    tick();
    chk("step_one_only", bus.icount, 32'd9);
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    #1;
    chk("resume_paused_lo", {31'b0, bus.paused}, 32'd0);
    chk("resume_pc_en", {31'b0, bus.pc_en}, 32'd1);
    bus.pc = 32'd6; bus.ecall = 1'b1; bus.a7 = 32'd10;
    #1;
    chk("misalign_pc_en", {31'b0, bus.pc_en}, 32'd0);
    tick();
    bus.ecall = 1'b0;
    chk("misalign_fault", {30'b0, bus.halted, bus.fault}, 32'd1);
    chk("fault_icount", bus.icount, 32'd9);
    bus.go = 1'b1; bus.step = 1'b1; bus.pc = 32'd0;
    tick();
    tick();
    chk("fault_sticky", {30'b0, bus.fault, bus.pc_en}, 32'd2);
    bus.go = 1'b0; bus.step = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("fault_rst", {29'b0, bus.paused, bus.halted, bus.fault}, 32'd0);
    chk("fault_rst_icount", bus.icount, 32'd0);
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0; bus.pc = 32'h0000_0FFC;
    #1;
    chk("top_pc_en", {31'b0, bus.pc_en}, 32'd1);
    chk("top_rom_addr", {22'b0, bus.rom_addr}, 32'h3FF);
    bus.pc = 32'h0000_1000;
    #1;
    chk("range_pc_en", {31'b0, bus.pc_en}, 32'd0);
    tick();
    chk("range_fault", {31'b0, bus.fault}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.go = 1'b1;
    tick();
    bus.go = 1'b0; bus.pc = 32'd0;
    tick();
    chk("halt_pre_icount", bus.icount, 32'd1);
    bus.pc = 32'd4; bus.ecall = 1'b1; bus.a7 = 32'd10;
    #1;
    chk("halt_pc_en", {31'b0, bus.pc_en}, 32'd0);
    tick();
    chk("halted_set", {30'b0, bus.halted, bus.fault}, 32'd2);
    bus.go = 1'b1; bus.step = 1'b1; bus.ecall = 1'b0;
    repeat (10) tick();
    chk("halt_sticky", {30'b0, bus.halted, bus.pc_en}, 32'd2);
    chk("halt_icount", bus.icount, 32'd1);
    bus.go = 1'b0; bus.step = 1'b0; bus.pc = 32'd8; rst = 1'b1;
    #1;
    chk("rst_abort_pc_en", {31'b0, bus.pc_en}, 32'd0);
    tick();
    rst = 1'b0;
    chk("halt_rst", {31'b0, bus.halted}, 32'd0);
    chk("halt_rst_icount", bus.icount, 32'd0);
    bus.go = 1'b1; bus.step = 1'b1; bus.pc = 32'd0;
    tick();
    bus.go = 1'b0; bus.step = 1'b0;
    tick();
    bus.pc = 32'd8; bus.ecall = 1'b1; bus.a7 = 32'd1;
    #1;
    chk("both_is_run", {30'b0, bus.paused, bus.pc_en}, 32'd1);
    tick();
    bus.ecall = 1'b0;
    chk("nop_ec_run", {30'b0, bus.paused, bus.pc_en}, 32'd1);
    chk("nop_ec_icount", bus.icount, 32'd2);
    @(negedge clk);
    force dut.icount_q = 32'hFFFF_FFFF;
    tick();
    tick();
    @(negedge clk);
    release dut.icount_q;
    tick();
    tick();
    chk("sat_icount", bus.icount, 32'hFFFF_FFFF);
    chk("sat_pc_en", {31'b0, bus.pc_en}, 32'd1);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
